// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: latches a word and shifts it out MSB-first,
// repeating for a programmable number of passes with a one-cycle gap.
// Ports: clk, reset (sync, active-high), start, abort, pattern[WIDTH],
//        repeat_n[CNT_W] in; X, valid, busy, done, Q[2] out (all registered).
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             X,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       Q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  state_e state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic x_q, x_d;
  logic valid_q, valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      hold_q  <= '0;
      bit_q   <= '0;
      pass_q  <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      hold_q  <= hold_d;
      bit_q   <= bit_d;
      pass_q  <= pass_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    hold_d  = hold_q;
    bit_d   = bit_q;
    pass_d  = pass_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          sr_d    = pattern;
          hold_d  = pattern;
          bit_d   = '0;
          pass_d  = (repeat_n == '0) ? CNT_W'(1) : repeat_n;
          x_d     = pattern[WIDTH-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (bit_q == LAST) begin
          if (pass_q > CNT_W'(1)) begin
            state_d = GAP;
            pass_d  = pass_q - 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          // rotate rather than shift so every register bit stays in use;
          // the wrapped bit is never presented
          sr_d    = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
          bit_d   = bit_q + 1'b1;
          x_d     = sr_q[WIDTH-2];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = SHIFT;
          sr_d    = hold_q;
          bit_d   = '0;
          x_d     = hold_q[WIDTH-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign X     = x_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign Q     = state_q;

endmodule
